// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: register index width, the x0 constant and the
// long-unit FSM state encoding.
package pipeline_pkg;

  localparam int unsigned REG_IDX_W = 5;
  localparam logic [REG_IDX_W-1:0] REG_ZERO = '0;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } longState_t;

endpackage

// File: rtl/long_op_tracker.sv
// Tracks the single outstanding mul/div op: destination register, busy FSM
// and a saturating watchdog whose expiry latches a sticky error.
module long_op_tracker
  import pipeline_pkg::*;
#(
  parameter int unsigned LONG_MAX = 64
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 start,
  input  logic [REG_IDX_W-1:0] startRd,
  input  logic                 done,
  output logic                 busy,
  output logic [REG_IDX_W-1:0] rd,
  output logic                 err
);

  localparam int unsigned WD_W = $clog2(LONG_MAX + 1);

  longState_t           state;
  longState_t           stateNext;
  logic [WD_W-1:0]      wdCnt;
  logic [WD_W-1:0]      wdNext;
  logic [REG_IDX_W-1:0] rdQ;
  logic                 errQ;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) state <= IDLE;
    else        state <= stateNext;
  end

  // Done is not bypassed: the op stays visible through the done cycle.
  always_comb begin
    stateNext = state;
    wdNext    = wdCnt;
    case (state)
      IDLE: begin
        if (start) begin
          stateNext = BUSY;
          wdNext    = '0;
        end
      end
      BUSY: begin
        if (wdCnt != WD_W'(LONG_MAX)) wdNext = wdCnt + WD_W'(1);
        if (done) stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      rdQ   <= REG_ZERO;
      wdCnt <= '0;
      errQ  <= 1'b0;
    end else begin
      wdCnt <= wdNext;
      if (state == IDLE && start) rdQ <= startRd;
      if (state == BUSY && wdNext == WD_W'(LONG_MAX)) errQ <= 1'b1;
    end
  end

  assign busy = (state == BUSY);
  assign rd   = rdQ;
  assign err  = errQ;

endmodule

// File: rtl/hazard_detection_unit.sv
// ID-stage hazard detector: load-use and long-latency (RAW/WAW/structural)
// hazards drive stall/bubble; also counts stall cycles.
module hazard_detection_unit
  import pipeline_pkg::*;
#(
  parameter int unsigned CNT_W    = 32,
  parameter int unsigned LONG_MAX = 64
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 ID_valid_i,
  input  logic [REG_IDX_W-1:0] ID_rs1_i,
  input  logic [REG_IDX_W-1:0] ID_rs2_i,
  input  logic                 ID_rs1_used_i,
  input  logic                 ID_rs2_used_i,
  input  logic [REG_IDX_W-1:0] ID_Rd_i,
  input  logic                 ID_RegWrite_i,
  input  logic                 ID_MemRead_i,
  input  logic                 ID_long_i,
  input  logic                 flush_i,
  input  logic                 LONG_done_i,
  output logic                 stall_o,
  output logic                 bubble_o,
  output logic                 long_busy_o,
  output logic                 long_err_o,
  output logic [CNT_W-1:0]     stall_cnt_o
);

  logic                 exLoadVld;
  logic [REG_IDX_W-1:0] exLoadRd;
  logic                 reads1;
  logic                 reads2;
  logic                 loadUse;
  logic                 longHaz;
  logic                 stallNow;
  logic                 accept;
  logic                 longBusy;
  logic [REG_IDX_W-1:0] longRd;

  assign reads1 = ID_rs1_used_i && (ID_rs1_i != REG_ZERO);
  assign reads2 = ID_rs2_used_i && (ID_rs2_i != REG_ZERO);

  assign loadUse = exLoadVld &&
                   ((reads1 && ID_rs1_i == exLoadRd) || (reads2 && ID_rs2_i == exLoadRd));

  // RAW on the pending result, WAW on its destination, or a second long op.
  assign longHaz = longBusy &&
                   ((reads1 && ID_rs1_i == longRd) ||
                    (reads2 && ID_rs2_i == longRd) ||
                    (ID_RegWrite_i && ID_Rd_i == longRd && longRd != REG_ZERO) ||
                    ID_long_i);

  assign stallNow = ID_valid_i && !flush_i && (loadUse || longHaz);
  assign accept   = ID_valid_i && !stallNow && !flush_i;

  assign stall_o  = stallNow;
  assign bubble_o = stallNow;

  // A bubble or flush clears the EX load, so load-use stalls last one cycle.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      exLoadVld   <= 1'b0;
      exLoadRd    <= REG_ZERO;
      stall_cnt_o <= '0;
    end else begin
      exLoadVld <= accept && ID_MemRead_i && ID_RegWrite_i && (ID_Rd_i != REG_ZERO);
      exLoadRd  <= ID_Rd_i;
      if (stallNow) stall_cnt_o <= stall_cnt_o + CNT_W'(1);
    end
  end

  long_op_tracker #(
    .LONG_MAX(LONG_MAX)
  ) u_longOpTracker (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .start  (accept && ID_long_i),
    .startRd(ID_RegWrite_i ? ID_Rd_i : REG_ZERO),
    .done   (LONG_done_i),
    .busy   (longBusy),
    .rd     (longRd),
    .err    (long_err_o)
  );

  assign long_busy_o = longBusy;

endmodule

// File: tb/tb_hazard_detection_unit.sv
// Randomized + directed bench for hazard_detection_unit against a behavioural
// model of the pipeline hazard rules.
module tb_hazard_detection_unit;

  localparam int unsigned CW   = 8;
  localparam int unsigned LMAX = 4;

  logic          clk_i;
  logic          rst_i;
  logic          ID_valid_i;
  logic [4:0]    ID_rs1_i;
  logic [4:0]    ID_rs2_i;
  logic          ID_rs1_used_i;
  logic          ID_rs2_used_i;
  logic [4:0]    ID_Rd_i;
  logic          ID_RegWrite_i;
  logic          ID_MemRead_i;
  logic          ID_long_i;
  logic          flush_i;
  logic          LONG_done_i;
  logic          stall_o;
  logic          bubble_o;
  logic          long_busy_o;
  logic          long_err_o;
  logic [CW-1:0] stall_cnt_o;

  int checks;
  int failures;

  // Model state: pending load in EX, outstanding long op, its age, totals.
  bit       mLoadPend;
  bit [4:0] mLoadRd;
  bit       mLongOut;
  bit [4:0] mLongRd;
  int       mLongAge;
  bit       mErr;
  int       mStalls;

  hazard_detection_unit #(
    .CNT_W   (CW),
    .LONG_MAX(LMAX)
  ) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .ID_valid_i   (ID_valid_i),
    .ID_rs1_i     (ID_rs1_i),
    .ID_rs2_i     (ID_rs2_i),
    .ID_rs1_used_i(ID_rs1_used_i),
    .ID_rs2_used_i(ID_rs2_used_i),
    .ID_Rd_i      (ID_Rd_i),
    .ID_RegWrite_i(ID_RegWrite_i),
    .ID_MemRead_i (ID_MemRead_i),
    .ID_long_i    (ID_long_i),
    .flush_i      (flush_i),
    .LONG_done_i  (LONG_done_i),
    .stall_o      (stall_o),
    .bubble_o     (bubble_o),
    .long_busy_o  (long_busy_o),
    .long_err_o   (long_err_o),
    .stall_cnt_o  (stall_cnt_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  function automatic bit idReads(input bit [4:0] r);
    return (r != 0) && ((ID_rs1_used_i && ID_rs1_i == r) || (ID_rs2_used_i && ID_rs2_i == r));
  endfunction

  function automatic bit expStall();
    bit haz;
    haz = mLoadPend && idReads(mLoadRd);
    if (mLongOut)
      haz = haz || idReads(mLongRd) || ID_long_i ||
            (ID_RegWrite_i && mLongRd != 0 && ID_Rd_i == mLongRd);
    return ID_valid_i && !flush_i && haz;
  endfunction

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check();
    bit s;
    s = expStall();
    cmp("stall", 32'(stall_o), 32'(s));
    cmp("bubble", 32'(bubble_o), 32'(s));
    cmp("long_busy", 32'(long_busy_o), 32'(mLongOut));
    cmp("long_err", 32'(long_err_o), 32'(mErr));
    cmp("stall_cnt", 32'(stall_cnt_o), 32'(mStalls));
  endtask

  task automatic modelReset();
    mLoadPend = 0; mLoadRd = 0; mLongOut = 0; mLongRd = 0;
    mLongAge = 0; mErr = 0; mStalls = 0;
  endtask

  task automatic modelUpdate();
    bit s;
    bit acc;
    s   = expStall();
    acc = ID_valid_i && !s && !flush_i;
    if (mLongOut) begin
      mLongAge++;
      if (mLongAge >= int'(LMAX)) mErr = 1;
      if (LONG_done_i) mLongOut = 0;
    end else if (acc && ID_long_i) begin
      mLongOut = 1;
      mLongRd  = ID_RegWrite_i ? ID_Rd_i : 5'd0;
      mLongAge = 0;
    end
    mLoadPend = acc && ID_MemRead_i && ID_RegWrite_i && ID_Rd_i != 0;
    mLoadRd   = ID_Rd_i;
    if (s) mStalls = (mStalls + 1) % (1 << CW);
  endtask

  task automatic clearIn();
    ID_valid_i = 0; ID_rs1_i = 0; ID_rs2_i = 0; ID_rs1_used_i = 0; ID_rs2_used_i = 0;
    ID_Rd_i = 0; ID_RegWrite_i = 0; ID_MemRead_i = 0; ID_long_i = 0;
    flush_i = 0; LONG_done_i = 0;
  endtask

  // Called at a negedge with inputs already driven.
  task automatic cycle();
    #1;
    check();
    @(posedge clk_i);
    modelUpdate();
    @(negedge clk_i);
  endtask

  task automatic doReset();
    rst_i = 0;
    modelReset();
    #1;
    check();
    cmp("rst_stall", 32'(stall_o), 32'd0);
    cmp("rst_busy", 32'(long_busy_o), 32'd0);
    cmp("rst_err", 32'(long_err_o), 32'd0);
    cmp("rst_cnt", 32'(stall_cnt_o), 32'd0);
    @(posedge clk_i);
    @(negedge clk_i);
    rst_i = 1;
  endtask

  initial begin
    checks = 0;
    failures = 0;
    clearIn();
    rst_i = 0;
    modelReset();
    @(negedge clk_i);
    doReset();

    // Load-use: lw x5 then a reader of x5 stalls exactly once.
    clearIn(); ID_valid_i = 1; ID_Rd_i = 5; ID_RegWrite_i = 1; ID_MemRead_i = 1; cycle();
    clearIn(); ID_valid_i = 1; ID_rs1_i = 5; ID_rs1_used_i = 1;
    #1 cmp("lu_stall", 32'(stall_o), 32'd1); cmp("lu_bubble", 32'(bubble_o), 32'd1);
    cycle();
    #1 cmp("lu_release", 32'(stall_o), 32'd0); cmp("lu_cnt", 32'(stall_cnt_o), 32'd1);
    cycle();
    clearIn(); ID_valid_i = 1; ID_Rd_i = 5; ID_RegWrite_i = 1; ID_MemRead_i = 1; cycle();
    clearIn(); ID_valid_i = 1; ID_rs1_i = 0; ID_rs1_used_i = 1;
    #1 cmp("lu_x0_src", 32'(stall_o), 32'd0);
    cycle();
    clearIn(); ID_valid_i = 1; ID_Rd_i = 0; ID_RegWrite_i = 1; ID_MemRead_i = 1; cycle();
    clearIn(); ID_valid_i = 1; ID_rs2_i = 0; ID_rs2_used_i = 1;
    #1 cmp("lu_x0_dst", 32'(stall_o), 32'd0);
    cycle();

    // Long RAW: div x7, reader of x7 stalls until the cycle after done.
    clearIn(); ID_valid_i = 1; ID_long_i = 1; ID_RegWrite_i = 1; ID_Rd_i = 7; cycle();
    for (int k = 1; k <= 6; k++) begin
      clearIn(); ID_valid_i = 1; ID_rs2_i = 7; ID_rs2_used_i = 1; LONG_done_i = (k == 6);
      #1;
      cmp("raw_stall", 32'(stall_o), 32'd1);
      cmp("raw_busy", 32'(long_busy_o), 32'd1);
      if (k == 4) cmp("wd_not_yet", 32'(long_err_o), 32'd0);
      if (k == 5) cmp("wd_err", 32'(long_err_o), 32'd1);
      cycle();
    end
    clearIn(); ID_valid_i = 1; ID_rs2_i = 7; ID_rs2_used_i = 1;
    #1 cmp("raw_release", 32'(stall_o), 32'd0); cmp("raw_idle", 32'(long_busy_o), 32'd0);
    cmp("raw_cnt", 32'(stall_cnt_o), 32'd7);
    cycle();
    clearIn(); LONG_done_i = 1; cycle();
    clearIn();
    #1 cmp("err_sticky", 32'(long_err_o), 32'd1); cmp("done_idle", 32'(long_busy_o), 32'd0);
    doReset();

    // WAW / structural while busy on x7; unrelated add proceeds.
    clearIn(); ID_valid_i = 1; ID_long_i = 1; ID_RegWrite_i = 1; ID_Rd_i = 7; cycle();
    clearIn(); ID_valid_i = 1; ID_RegWrite_i = 1; ID_Rd_i = 7;
    #1 cmp("waw_stall", 32'(stall_o), 32'd1);
    cycle();
    clearIn(); ID_valid_i = 1; ID_long_i = 1; ID_RegWrite_i = 1; ID_Rd_i = 9;
    #1 cmp("struct_stall", 32'(stall_o), 32'd1);
    cycle();
    clearIn(); ID_valid_i = 1; ID_RegWrite_i = 1; ID_Rd_i = 8; ID_rs1_i = 9; ID_rs1_used_i = 1;
    LONG_done_i = 1;
    #1 cmp("indep_go", 32'(stall_o), 32'd0);
    cycle();
    clearIn();
    #1 cmp("waw_cnt", 32'(stall_cnt_o), 32'd2); cmp("waw_noerr", 32'(long_err_o), 32'd0);
    cycle();

    // Flush kills the hazard and the capture.
    clearIn(); ID_valid_i = 1; ID_Rd_i = 5; ID_RegWrite_i = 1; ID_MemRead_i = 1; cycle();
    clearIn(); ID_valid_i = 1; ID_rs1_i = 5; ID_rs1_used_i = 1; flush_i = 1;
    #1 cmp("flush_stall", 32'(stall_o), 32'd0);
    cycle();
    flush_i = 0;
    #1 cmp("flush_noload", 32'(stall_o), 32'd0);
    cycle();
    clearIn(); ID_valid_i = 1; ID_long_i = 1; ID_RegWrite_i = 1; ID_Rd_i = 7; flush_i = 1; cycle();
    clearIn();
    #1 cmp("flush_nolong", 32'(long_busy_o), 32'd0);
    cycle();

    // Asynchronous reset while busy; later done stays ignored.
    clearIn(); ID_valid_i = 1; ID_long_i = 1; ID_RegWrite_i = 1; ID_Rd_i = 7; cycle();
    clearIn();
    #1 cmp("pre_rst_busy", 32'(long_busy_o), 32'd1);
    doReset();
    clearIn(); LONG_done_i = 1; cycle();
    clearIn();
    #1 cmp("post_rst_idle", 32'(long_busy_o), 32'd0);
    cycle();

    // Randomized traffic; small register range to provoke matches.
    for (int n = 0; n < 3000; n++) begin
      if (n % 600 == 599) doReset();
      ID_valid_i    = ($urandom_range(0, 9) != 0);
      ID_rs1_i      = 5'($urandom_range(0, 3));
      ID_rs2_i      = 5'($urandom_range(0, 3));
      ID_rs1_used_i = ($urandom_range(0, 9) < 7);
      ID_rs2_used_i = ($urandom_range(0, 9) < 5);
      ID_Rd_i       = 5'($urandom_range(0, 3));
      ID_RegWrite_i = ($urandom_range(0, 9) < 7);
      ID_MemRead_i  = ($urandom_range(0, 9) < 3);
      ID_long_i     = ($urandom_range(0, 9) == 0);
      flush_i       = ($urandom_range(0, 9) == 0);
      LONG_done_i   = ($urandom_range(0, 6) == 0);
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hazard_detection_unit.md
Name: hazard_detection_unit

Overview:
- ID-stage hazard detector for the 5-stage RISC-V pipeline. It covers the hazards the EX-stage forwarding path cannot resolve.
- Load-use: a load in EX whose Rd is read by the instruction in ID.
- Long-latency hazard: a single multi-cycle mul/div unit whose destination register stays busy until it signals completion.
- Drives PC / IF-ID hold and ID-EX bubble insertion, and keeps a stall-cycle counter plus a watchdog on the long unit.

Parameters:
- CNT_W, 32, width of stall-cycle counter.
- LONG_MAX, 64, cycles a long op may stay outstanding before long_err_o latches.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  asynchronous, active-low reset.
- ID_valid_i  in  1  ID holds a real instruction.
- ID_rs1_i  in  5  source 1 index.
- ID_rs2_i  in  5  source 2 index.
- ID_rs1_used_i  in  1  instruction reads rs1.
- ID_rs2_used_i  in  1  instruction reads rs2.
- ID_Rd_i  in  5  destination index.
- ID_RegWrite_i  in  1  instruction writes Rd.
- ID_MemRead_i  in  1  instruction is a load.
- ID_long_i  in  1  instruction goes to the long unit.
- flush_i  in  1  taken branch in EX kills the ID instruction this cycle.
- LONG_done_i  in  1  one-cycle pulse: long unit writing result.
- stall_o  out  1  hold PC and IF/ID.
- bubble_o  out  1  load NOP into ID/EX.
- long_busy_o  out  1  long unit outstanding.
- long_err_o  out  1  sticky watchdog error.
- stall_cnt_o  out  CNT_W  total stall cycles.

Behaviour:
- Reset (rst_i low, async): all state clears and outputs read 0.
  - State cleared: ex_load_vld, ex_load_rd, FSM = IDLE, long_rd, wd_cnt, long_err_o, stall_cnt_o.
  - Outputs 0: stall_o, bubble_o, long_busy_o, long_err_o, stall_cnt_o.
  - Reset mid long op abandons the op; any later LONG_done_i is ignored in IDLE.
- reads1 = ID_rs1_used_i && ID_rs1_i != 0; reads2 likewise for rs2.
- Load-use hazard: ex_load_vld && ((reads1 && ID_rs1_i == ex_load_rd) || (reads2 && ID_rs2_i == ex_load_rd)).
- Long hazard: FSM in BUSY and any of the following:
  - reads1 && ID_rs1_i == long_rd, or reads2 && ID_rs2_i == long_rd (RAW).
  - ID_RegWrite_i && ID_Rd_i == long_rd && long_rd != 0 (WAW).
  - ID_long_i (structural).
- Output combination:
  - stall_o = ID_valid_i && !flush_i && (load-use || long hazard). Combinational.
  - bubble_o = stall_o.
  - flush_i overrides: stall_o = 0.
- accept = ID_valid_i && !stall_o && !flush_i.
- ex_load register, updated every cycle:
  - ex_load_vld <= accept && ID_MemRead_i && ID_RegWrite_i && ID_Rd_i != 0.
  - ex_load_rd <= ID_Rd_i.
  - A bubble or flush therefore clears ex_load_vld, so a load-use stall lasts exactly 1 cycle.
- Long FSM, states IDLE and BUSY:
  - IDLE -> BUSY on accept && ID_long_i. Latch long_rd = ID_RegWrite_i ? ID_Rd_i : 0. Clear wd_cnt to 0.
  - BUSY -> IDLE on LONG_done_i.
  - Done is not bypassed: hazard checks still see BUSY in the done cycle, and release occurs the next cycle. WB/forwarding supplies the value from then on.
  - LONG_done_i in IDLE is ignored.
  - long_busy_o = (state == BUSY).
- Watchdog:
  - In BUSY, wd_cnt increments per cycle, saturating at LONG_MAX.
  - When wd_cnt reaches LONG_MAX, long_err_o <= 1. It is sticky until reset.
  - The FSM stays BUSY until done.
- stall_cnt_o increments on every cycle stall_o == 1 and wraps modulo 2^CNT_W.
- Simultaneous events:
  - Load-use and long hazard in the same cycle: one stall cycle is counted.
  - flush_i with a hazard: no stall and no capture.
  - accept of a long op while LONG_done_i is asserted cannot happen, because structural stall blocks it.

Decomposition:
- Shared package (pipeline_pkg) holds:
  - REG_IDX_W = 5.
  - Long FSM state enum {IDLE, BUSY}.
  - Constant REG_ZERO.
- One natural sub-module: long_op_tracker. It holds the FSM, long_rd and the watchdog, and exports busy/rd/err. The top level keeps the load-use register, hazard compare and stall counter.

Test Plan:
- Load-use: lw x5 accepted; next cycle ID reads rs1 = x5 -> stall_o = bubble_o = 1 for exactly 1 cycle, stall_cnt_o = 1. Same pattern with rs1 = x0 or rd = x0 -> no stall.
- Long RAW: div x7 accepted; next ID reads rs2 = x7 -> stall for every cycle until LONG_done_i (at cycle 6), then stall_o = 0 on cycle 7. long_busy_o is 1 from cycle 1 to cycle 6.
- Long WAW/structural while BUSY on x7: an add writing x7 stalls; a second mul stalls; an add x8 reading x9 proceeds (stall_o = 0).
- flush_i asserted during a load-use hazard -> stall_o = 0, ex_load_vld next cycle = 0, no FSM transition for a killed long op.
- Watchdog: LONG_MAX = 4, long op never completes -> long_err_o rises after 4 BUSY cycles and stays 1 after LONG_done_i. Reset clears it.
- Reset asserted while BUSY -> all outputs 0 immediately (async). A subsequent LONG_done_i leaves the FSM IDLE.
